mem_stage: RTL

Memory-access stage of the five-stage MIPS pipeline, directly downstream of the execute stage. Captures the execute-to-memory bus into its pipeline register and waits for the data SRAM response of any load or store. Aligns and extends load data and drives the writeback bus and the register-file forwarding bus. Requests a pipeline stall while a memory response is outstanding.

---
 rtl/mem_stage_pkg.sv | 40 ++++
 rtl/mem_load_align.sv | 32 +++
 rtl/mem_stage.sv | 97 +++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, stall encoding,
// load/store opcodes, response FSM states and the execute-to-memory bus layout.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD_DEF = 84;
  localparam int MEM_TO_WB_WD_DEF = 70;
  localparam int MEM_TO_RF_WD_DEF = 38;
  localparam int STALL_BUS_DEF    = 6;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [1:0]  addr_lo;
    logic [5:0]  ld_st_op;
    logic [31:0] ex_pc;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

endpackage

// File: rtl/mem_load_align.sv
// Load alignment: picks the addressed byte/half/word out of the SRAM word and
// sign- or zero-extends it. Unaligned halfwords simply ignore addr_lo[0].
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [5:0]  ld_st_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = raw[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];

  // NOTE: every always_comb output gets a value on every path; the default
  // below is what keeps synthesis from inferring a latch.
  always_comb begin
    result = 32'b0;
    unique case (ld_st_op)
      OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {24'b0, byte_sel};
      OP_LH:   result = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  result = {16'b0, half_sel};
      OP_LW:   result = raw;
      default: result = 32'b0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: pipeline register, SRAM response FSM, load data
// buffering and the writeback/forwarding buses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int EX_TO_MEM_WD = EX_TO_MEM_WD_DEF,
  parameter int MEM_TO_WB_WD = MEM_TO_WB_WD_DEF,
  parameter int MEM_TO_RF_WD = MEM_TO_RF_WD_DEF,
  parameter int StallBus     = STALL_BUS_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [StallBus-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  input  logic                    data_sram_data_ok,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
  output logic                    stallreq_for_mem
);

  ex_to_mem_t ex_in;
  ex_to_mem_t ex_to_mem_q, ex_to_mem_d;
  mem_state_e state_q, state_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;

  logic        bubble;
  logic        advance;
  logic        resp_now;
  logic [31:0] raw;
  logic [31:0] load_result;
  logic [31:0] rf_wdata;
  logic        unused_ok;

  assign ex_in = ex_to_mem_t'(ex_to_mem_bus);

  assign bubble   = (stall[3] == Stop) && (stall[4] == NoStop);
  assign advance  = (stall[3] == NoStop);
  assign resp_now = (state_q == ST_WAIT) && data_sram_data_ok;

  always_comb begin
    ex_to_mem_d = ex_to_mem_q;
    if (bubble)       ex_to_mem_d = '0;
    else if (advance) ex_to_mem_d = ex_in;
  end

  // A freshly loaded op must start its own wait, so a response strobe seen on
  // the advancing cycle belongs to the old op and is not buffered.
  always_comb begin
    state_d     = state_q;
    rdata_buf_d = rdata_buf_q;
    if (advance && !bubble) begin
      state_d = ex_in.mem_en ? ST_WAIT : ST_IDLE;
    end else if (bubble) begin
      state_d = ST_IDLE;
    end else if (resp_now) begin
      state_d     = ST_DONE;
      rdata_buf_d = data_sram_rdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, and the small
  // rdata buffer is reset along with the control state so outputs start at 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_to_mem_q <= '0;
      state_q     <= ST_IDLE;
      rdata_buf_q <= '0;
    end else begin
      ex_to_mem_q <= ex_to_mem_d;
      state_q     <= state_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  assign stallreq_for_mem = (state_q == ST_WAIT) && !data_sram_data_ok;

  // Zero-wait loads bypass the buffer so data reaches writeback the same cycle.
  assign raw = resp_now ? data_sram_rdata : rdata_buf_q;

  mem_load_align u_load_align (
    .ld_st_op (ex_to_mem_q.ld_st_op),
    .addr_lo  (ex_to_mem_q.addr_lo),
    .raw      (raw),
    .result   (load_result)
  );

  assign rf_wdata = ex_to_mem_q.sel_rf_res ? load_result : ex_to_mem_q.ex_result;

  assign mem_to_wb_bus = {ex_to_mem_q.ex_pc, ex_to_mem_q.rf_we,
                          ex_to_mem_q.rf_waddr, rf_wdata};
  assign mem_to_rf_bus = {ex_to_mem_q.rf_we, ex_to_mem_q.rf_waddr, rf_wdata};

  // Byte enables and the other stages' stall bits are consumed elsewhere.
  assign unused_ok = ^{ex_to_mem_q.mem_wen, stall};

endmodule
